// File: rtl/sd_mirror_sched.sv
// sd_mirror_sched
//   Non-atomic mirror scheduler. One upstream srdy/drdy stream arrives, and each
//   word carries a destination mask. The held word goes to each selected receiver
//   as soon as that receiver is ready. The next word is accepted only once every
//   selected receiver has taken the current one. Words with an empty mask are
//   consumed and counted. A per-receiver watchdog flags words that stay pending
//   for too long.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   c_srdy     upstream word valid
//   c_drdy     upstream word accepted this cycle (combinational from p_drdy)
//   c_data     upstream data
//   c_dst      destination mask for c_data
//   p_srdy     per-receiver valid (the pending mask)
//   p_drdy     per-receiver ready
//   p_data     held data, common to all receivers
//   busy       a word is held with at least one pending receiver
//   done       one-cycle pulse after the last pending receiver took the word
//   stall_err  sticky per-receiver stall flags
//   err_clr    synchronous clear of stall_err
//   drop_cnt   saturating count of accepted words with an empty mask
module sd_mirror_sched #(
  parameter int mirror_cnt  = 2,
  parameter int width       = 32,
  parameter int stall_limit = 256,
  parameter int cnt_w       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  c_srdy,
  output logic                  c_drdy,
  input  logic [width-1:0]      c_data,
  input  logic [mirror_cnt-1:0] c_dst,
  output logic [mirror_cnt-1:0] p_srdy,
  input  logic [mirror_cnt-1:0] p_drdy,
  output logic [width-1:0]      p_data,
  output logic                  busy,
  output logic                  done,
  output logic [mirror_cnt-1:0] stall_err,
  input  logic                  err_clr,
  output logic [cnt_w-1:0]      drop_cnt
);

  // The age counter stops at stall_limit. The trigger value stall_limit-1 is
  // therefore crossed only once per word, so a cleared flag is not re-raised
  // by the same stalled word.
  localparam logic             WD_EN    = (stall_limit > 0) ? 1'b1 : 1'b0;
  localparam logic [cnt_w-1:0] AGE_MAX  = cnt_w'(stall_limit);
  localparam logic [cnt_w-1:0] AGE_TRIG = (stall_limit > 0) ? cnt_w'(stall_limit - 1) : cnt_w'(0);
  localparam logic [cnt_w-1:0] DROP_MAX = {cnt_w{1'b1}};
  localparam logic [mirror_cnt-1:0] MASK_ZERO = {mirror_cnt{1'b0}};

  logic [mirror_cnt-1:0] pend_q, pend_d;
  logic [width-1:0]      data_q, data_d;
  logic [cnt_w-1:0]      age_q, age_d;
  logic [cnt_w-1:0]      drop_q, drop_d;
  logic [mirror_cnt-1:0] err_q, err_d;
  logic                  done_q, done_d;

  logic [mirror_cnt-1:0] take_s;
  logic [mirror_cnt-1:0] next_pend_s;
  logic                  busy_s;
  logic                  last_s;
  logic                  accept_s;
  logic                  load_s;
  logic                  drop_s;
  logic                  wd_hit_s;

  // Delivery and handshake decode. c_drdy reopens in the cycle of the final take
  // so that back-to-back words flow without a bubble.
  always_comb begin
    take_s      = pend_q & p_drdy;
    next_pend_s = pend_q & ~take_s;
    busy_s      = (pend_q != MASK_ZERO);
    last_s      = busy_s & (next_pend_s == MASK_ZERO);
    accept_s    = c_srdy & (~busy_s | last_s);
    load_s      = accept_s & (c_dst != MASK_ZERO);
    drop_s      = accept_s & (c_dst == MASK_ZERO);
    wd_hit_s    = WD_EN & busy_s & (age_q == AGE_TRIG);
  end

  // Next-state computation for the pending mask, data, age, errors and drop count.
  always_comb begin
    pend_d = next_pend_s;
    data_d = data_q;
    age_d  = age_q;
    err_d  = err_q;
    drop_d = drop_q;
    done_d = last_s;

    // A new load overrides the clear of the previous word's last take.
    if (load_s) begin
      pend_d = c_dst;
      data_d = c_data;
      age_d  = cnt_w'(0);
    end else if (busy_s && !last_s && (age_q != AGE_MAX)) begin
      age_d = age_q + cnt_w'(1);
    end else begin
      age_d = age_q;
    end

    // A set and a clear in the same cycle: the newly flagged receivers stay set.
    if (err_clr) begin
      err_d = MASK_ZERO;
    end else begin
      err_d = err_q;
    end
    if (wd_hit_s) begin
      err_d = err_d | next_pend_s;
    end else begin
      err_d = err_d;
    end

    if (drop_s && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + cnt_w'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= MASK_ZERO;
      data_q <= {width{1'b0}};
      age_q  <= cnt_w'(0);
      err_q  <= MASK_ZERO;
      drop_q <= cnt_w'(0);
      done_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
      age_q  <= age_d;
      err_q  <= err_d;
      drop_q <= drop_d;
      done_q <= done_d;
    end
  end

  assign c_drdy    = ~busy_s | last_s;
  assign p_srdy    = pend_q;
  assign p_data    = data_q;
  assign busy      = busy_s;
  assign done      = done_q;
  assign stall_err = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_sd_mirror_sched.sv
module tb_sd_mirror_sched;

  logic        clk;
  logic        rst_n;
  logic        c_srdy;
  logic        c_drdy;
  logic [7:0]  c_data;
  logic [2:0]  c_dst;
  logic [2:0]  p_srdy;
  logic [2:0]  p_drdy;
  logic [7:0]  p_data;
  logic        busy;
  logic        done;
  logic [2:0]  stall_err;
  logic        err_clr;
  logic [15:0] drop_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0] exp_q [0:2][$];

  sd_mirror_sched #(
    .mirror_cnt (3),
    .width      (8),
    .stall_limit(4),
    .cnt_w      (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .c_srdy   (c_srdy),
    .c_drdy   (c_drdy),
    .c_data   (c_data),
    .c_dst    (c_dst),
    .p_srdy   (p_srdy),
    .p_drdy   (p_drdy),
    .p_data   (p_data),
    .busy     (busy),
    .done     (done),
    .stall_err(stall_err),
    .err_clr  (err_clr),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (inputs are driven here).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c_srdy = 1'b0; c_data = 8'h00; c_dst = 3'b000; p_drdy = 3'b000; err_clr = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk_cnt++; if (p_srdy !== 3'b000) $display("FAIL rst_p_srdy got=%b exp=000", p_srdy); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else pass_cnt++;
    chk_cnt++; if (stall_err !== 3'b000) $display("FAIL rst_stall_err got=%b exp=000", stall_err); else pass_cnt++;
    chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); else pass_cnt++;
    chk_cnt++; if (p_data !== 8'h00) $display("FAIL rst_p_data got=%h exp=00", p_data); else pass_cnt++;
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL rst_c_drdy got=%b exp=1", c_drdy); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_broadcast();
    c_srdy = 1'b1; c_data = 8'hA5; c_dst = 3'b111; p_drdy = 3'b111;
    @(negedge clk);
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t1_c_drdy_c0 got=%b exp=1", c_drdy); else pass_cnt++;
    chk_cnt++; if (p_srdy !== 3'b000) $display("FAIL t1_p_srdy_c0 got=%b exp=000", p_srdy); else pass_cnt++;
    tick();
    c_data = 8'h5A;
    @(negedge clk);
    chk_cnt++; if (p_srdy !== 3'b111) $display("FAIL t1_p_srdy_c1 got=%b exp=111", p_srdy); else pass_cnt++;
    chk_cnt++; if (p_data !== 8'hA5) $display("FAIL t1_p_data_c1 got=%h exp=a5", p_data); else pass_cnt++;
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t1_c_drdy_c1 got=%b exp=1", c_drdy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL t1_done_c1 got=%b exp=0", done); else pass_cnt++;
    tick();
    c_data = 8'h3C;
    @(negedge clk);
    chk_cnt++; if (p_data !== 8'h5A) $display("FAIL t1_p_data_c2 got=%h exp=5a", p_data); else pass_cnt++;
    chk_cnt++; if (p_srdy !== 3'b111) $display("FAIL t1_p_srdy_c2 got=%b exp=111", p_srdy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1) $display("FAIL t1_done_c2 got=%b exp=1", done); else pass_cnt++;
    tick();
    c_srdy = 1'b0;
    @(negedge clk);
    chk_cnt++; if (p_data !== 8'h3C) $display("FAIL t1_p_data_c3 got=%h exp=3c", p_data); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL t1_busy_c4 got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1) $display("FAIL t1_done_c4 got=%b exp=1", done); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (done !== 1'b0) $display("FAIL t1_done_c5 got=%b exp=0", done); else pass_cnt++;
    tick();
  endtask

  task automatic test_partial();
    int takes0;
    takes0 = 0;
    c_srdy = 1'b1; c_data = 8'h11; c_dst = 3'b101; p_drdy = 3'b000;
    @(negedge clk);
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t2_c_drdy_c0 got=%b exp=1", c_drdy); else pass_cnt++;
    tick();
    c_srdy = 1'b0; p_drdy = 3'b001;
    @(negedge clk);
    if (p_srdy[0] && p_drdy[0]) takes0++;
    chk_cnt++; if (p_srdy !== 3'b101) $display("FAIL t2_p_srdy_c1 got=%b exp=101", p_srdy); else pass_cnt++;
    chk_cnt++; if (c_drdy !== 1'b0) $display("FAIL t2_c_drdy_c1 got=%b exp=0", c_drdy); else pass_cnt++;
    tick();
    p_drdy = 3'b001;
    @(negedge clk);
    if (p_srdy[0] && p_drdy[0]) takes0++;
    chk_cnt++; if (p_srdy !== 3'b100) $display("FAIL t2_p_srdy_c2 got=%b exp=100", p_srdy); else pass_cnt++;
    chk_cnt++; if (c_drdy !== 1'b0) $display("FAIL t2_c_drdy_c2 got=%b exp=0", c_drdy); else pass_cnt++;
    tick();
    p_drdy = 3'b101;
    @(negedge clk);
    if (p_srdy[0] && p_drdy[0]) takes0++;
    chk_cnt++; if (p_srdy !== 3'b100) $display("FAIL t2_p_srdy_c3 got=%b exp=100", p_srdy); else pass_cnt++;
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t2_c_drdy_c3 got=%b exp=1", c_drdy); else pass_cnt++;
    chk_cnt++; if (p_data !== 8'h11) $display("FAIL t2_p_data_c3 got=%h exp=11", p_data); else pass_cnt++;
    tick();
    p_drdy = 3'b000;
    @(negedge clk);
    chk_cnt++; if (p_srdy !== 3'b000) $display("FAIL t2_p_srdy_c4 got=%b exp=000", p_srdy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1) $display("FAIL t2_done_c4 got=%b exp=1", done); else pass_cnt++;
    chk_cnt++; if (takes0 !== 1) $display("FAIL t2_rx0_takes got=%0d exp=1", takes0); else pass_cnt++;
    tick();
  endtask

  task automatic test_zero_mask();
    c_srdy = 1'b1; c_dst = 3'b000; p_drdy = 3'b111;
    for (int k = 0; k < 3; k++) begin
      c_data = 8'(8'hE0 + k);
      @(negedge clk);
      chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t3_c_drdy_%0d got=%b exp=1", k, c_drdy); else pass_cnt++;
      chk_cnt++; if (p_srdy !== 3'b000) $display("FAIL t3_p_srdy_%0d got=%b exp=000", k, p_srdy); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL t3_done_%0d got=%b exp=0", k, done); else pass_cnt++;
      tick();
    end
    c_srdy = 1'b0;
    @(negedge clk);
    chk_cnt++; if (drop_cnt !== 16'd3) $display("FAIL t3_drop_cnt got=%0d exp=3", drop_cnt); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL t3_done_end got=%b exp=0", done); else pass_cnt++;
    tick();
  endtask

  task automatic test_watchdog();
    c_srdy = 1'b1; c_data = 8'h77; c_dst = 3'b010; p_drdy = 3'b000;
    tick();
    c_srdy = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk_cnt++; if (stall_err !== 3'b000) $display("FAIL t4_err_early got=%b exp=000", stall_err); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (stall_err !== 3'b010) $display("FAIL t4_err_set got=%b exp=010", stall_err); else pass_cnt++;
    chk_cnt++; if (p_srdy !== 3'b010) $display("FAIL t4_pend_kept got=%b exp=010", p_srdy); else pass_cnt++;
    tick();
    p_drdy = 3'b010;
    @(negedge clk);
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t4_c_drdy got=%b exp=1", c_drdy); else pass_cnt++;
    tick();
    p_drdy = 3'b000; err_clr = 1'b1;
    @(negedge clk);
    chk_cnt++; if (p_srdy !== 3'b000) $display("FAIL t4_delivered got=%b exp=000", p_srdy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b1) $display("FAIL t4_done got=%b exp=1", done); else pass_cnt++;
    chk_cnt++; if (stall_err !== 3'b010) $display("FAIL t4_err_sticky got=%b exp=010", stall_err); else pass_cnt++;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    chk_cnt++; if (stall_err !== 3'b000) $display("FAIL t4_err_clr got=%b exp=000", stall_err); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    c_srdy = 1'b1; c_data = 8'hC3; c_dst = 3'b110; p_drdy = 3'b000;
    tick();
    c_srdy = 1'b0;
    @(negedge clk);
    chk_cnt++; if (p_srdy !== 3'b110) $display("FAIL t5_pre got=%b exp=110", p_srdy); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    chk_cnt++; if (p_srdy !== 3'b000) $display("FAIL t5_p_srdy got=%b exp=000", p_srdy); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL t5_busy got=%b exp=0", busy); else pass_cnt++;
    chk_cnt++; if (p_data !== 8'h00) $display("FAIL t5_p_data got=%h exp=00", p_data); else pass_cnt++;
    chk_cnt++; if (drop_cnt !== 16'd0) $display("FAIL t5_drop_cnt got=%0d exp=0", drop_cnt); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    c_srdy = 1'b1; c_data = 8'h9E; c_dst = 3'b011; p_drdy = 3'b011;
    @(negedge clk);
    chk_cnt++; if (c_drdy !== 1'b1) $display("FAIL t5_c_drdy got=%b exp=1", c_drdy); else pass_cnt++;
    tick();
    c_srdy = 1'b0;
    @(negedge clk);
    chk_cnt++; if (p_srdy !== 3'b011) $display("FAIL t5_p_srdy_load got=%b exp=011", p_srdy); else pass_cnt++;
    chk_cnt++; if (p_data !== 8'h9E) $display("FAIL t5_p_data_load got=%h exp=9e", p_data); else pass_cnt++;
    tick();
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1) $display("FAIL t5_done got=%b exp=1", done); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    int         words;
    int         drops;
    int         cyc;
    logic       hold;
    logic       exp_drdy;
    logic [2:0] mdl;
    logic [7:0] front;
    words = 0; drops = 0; cyc = 0; hold = 1'b0; mdl = 3'b000;
    p_drdy = 3'b000; c_srdy = 1'b0;
    while (((words < 10000) || (mdl != 3'b000)) && (cyc < 60000)) begin
      if (!hold) begin
        if ((words < 10000) && ($urandom_range(0, 3) != 0)) begin
          c_srdy = 1'b1;
          c_data = 8'($urandom);
          c_dst  = 3'($urandom_range(0, 7));
        end else begin
          c_srdy = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) p_drdy[i] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_drdy = (mdl == 3'b000) || ((mdl & ~p_drdy) == 3'b000);
      chk_cnt++; if (c_drdy !== exp_drdy) $display("FAIL t6_c_drdy cyc=%0d got=%b exp=%b", cyc, c_drdy, exp_drdy); else pass_cnt++;
      chk_cnt++; if (p_srdy !== mdl) $display("FAIL t6_p_srdy cyc=%0d got=%b exp=%b", cyc, p_srdy, mdl); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        if (mdl[i] && p_drdy[i]) begin
          chk_cnt++;
          if (exp_q[i].size() == 0) begin
            $display("FAIL t6_rx%0d_extra cyc=%0d got=%h exp=none", i, cyc, p_data);
          end else begin
            front = exp_q[i].pop_front();
            if (p_data !== front) $display("FAIL t6_rx%0d_data cyc=%0d got=%h exp=%h", i, cyc, p_data, front);
            else pass_cnt++;
          end
        end
      end
      if (c_srdy && exp_drdy) begin
        for (int i = 0; i < 3; i++) if (c_dst[i]) exp_q[i].push_back(c_data);
        words++;
        if (c_dst == 3'b000) drops++;
        mdl = c_dst;
      end else begin
        mdl = mdl & ~p_drdy;
      end
      hold = c_srdy && !exp_drdy;
      tick();
      cyc++;
    end
    c_srdy = 1'b0; p_drdy = 3'b000;
    chk_cnt++; if (cyc >= 60000) $display("FAIL t6_timeout got=%0d exp<60000", cyc); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      chk_cnt++; if (exp_q[i].size() != 0) $display("FAIL t6_rx%0d_lost got=%0d exp=0", i, exp_q[i].size()); else pass_cnt++;
    end
    @(negedge clk);
    chk_cnt++; if (drop_cnt !== 16'(drops)) $display("FAIL t6_drop_cnt got=%0d exp=%0d", drop_cnt, drops); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_broadcast();
    test_partial();
    test_zero_mask();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
